obi_mem_responder: RTL and testbench
====================================

Name: obi_mem_responder

Overview:
- Memory-side responder for the core's instruction or data request/grant/rvalid port.
- Owns a small word-addressed backing RAM and grants requests, optionally with pseudo-random stalls.
- Returns responses strictly in order after a fixed minimum latency.
- Drives simulation benches and gives the formal harness a concrete, protocol-correct slave.
- One instance serves the instruction port (we_i tied 0); a second serves the data port.

Parameters:
- MEM_WORDS_LOG2, 8, log2 of RAM depth in 32-bit words (256 words).
- LATENCY, 1, cycles from the grant edge to the earliest rvalid; legal range 1..7.
- MAX_OUTSTANDING, 2, response-queue depth, i.e. granted but not yet answered; legal range 1..4.
- LFSR_SEED, 16'hACE1, reset value of the stall LFSR; must be nonzero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- stall_en_i  in  1  1 = LFSR-driven grant stalls; 0 = grant whenever possible.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  32  byte address.
- we_i  in  1  1 = write.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid; one cycle per accepted request.
- rdata_o  out  32  read data; 0 for write responses.
- outstanding_o  out  3  current queue occupancy.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, outstanding_o=0, LFSR=LFSR_SEED.
- RAM contents are not reset. Reset mid-transaction discards every queued response; none is emitted afterwards.
- Word index = addr_i[MEM_WORDS_LOG2+1:2]. addr_i[1:0] and higher bits are ignored, so addresses alias (wrap) silently.
- pop = rvalid_o this cycle.
- full = (count == MAX_OUTSTANDING) && !pop.
- stall = stall_en_i && lfsr[0].
- gnt_o = req_i && !full && !stall. gnt_o is combinational and never asserted without req_i.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Advances every cycle regardless of req_i.
- Accept (gnt_o=1), write: RAM bytes with be_i[k]=1 updated at that clock edge; queued rdata = 0.
- Accept, read: RAM word sampled in the grant cycle is queued. A write granted in the same cycle is impossible (single port).
- Read-after-write in consecutive grants returns the new data.
- Each queue entry holds {rdata, countdown}. countdown loads LATENCY-1 on push and decrements each cycle while >0.
- rvalid_o = (count>0) && (head countdown==0). rdata_o = head rdata while rvalid_o, else 0.
- Responses are strictly FIFO; a younger entry never overtakes an older one.
- With LATENCY=1 and no stalls: back-to-back grants each cycle, rvalid one cycle after each grant, 1 beat/cycle sustained.
- Simultaneous push and pop: count unchanged. A grant is permitted at full when pop occurs that cycle.
- outstanding_o = count. count never exceeds MAX_OUTSTANDING.

Decomposition:
- Shared package obi_mem_pkg: obi_req_t {addr, we, be, wdata}, obi_rsp_t {rdata}, LFSR tap constant, LFSR_SEED default.
- Sub-module obi_rsp_queue: parameterised FIFO with per-entry countdown, push/pop and head-ready output. The top level keeps RAM, LFSR and grant logic.

Test Plan:
- Write-read, stall_en=0, LATENCY=1: write addr 0x10, be 4'hF, data 0xDEADBEEF; next cycle read 0x10 -> gnt both cycles; rvalid at cycles +1 and +2; second rdata 0xDEADBEEF, first 0.
- Byte enables: preload 0x11223344 at 0x20; write be 4'b0101, data 0xAABBCCDD; read 0x20 -> 0x11BB33DD.
- Back-pressure: LATENCY=3, MAX_OUTSTANDING=2, req held high -> two grants, then gnt=0 with outstanding_o=2. Third grant lands in the same cycle as the first rvalid; rdata order matches issue order.
- Aliasing: MEM_WORDS_LOG2=8; write 0x1234 at addr 0x400; read addr 0x000 -> 0x1234. Low address bits 0x3 are ignored.
- Random stalls: stall_en=1, req held high 200 cycles -> every gnt cycle has req; rvalid count equals gnt count after drain; gnt pattern matches the LFSR seeded with 16'hACE1.
- Reset mid-flight: LATENCY=4, two reads granted, rst_ni low for 1 cycle before any rvalid -> rvalid stays 0 after release; outstanding_o=0; next request grants normally.

Source files
------------

// File: rtl/obi_mem_pkg.sv
// Shared types, LFSR constants and byte-merge helper for the OBI memory responder.
package obi_mem_pkg;

    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } obi_rsp_t;

    // Right-shifting Fibonacci step: taps 16/14/13/11 map to bits 0/2/3/5.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// Request/grant/rvalid bus between a core port (master) and the memory responder (slave).
interface obi_mem_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_rsp_queue.sv
// In-order response FIFO; each entry counts down from LATENCY-1 and is ready at zero.
module obi_rsp_queue
    import obi_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  obi_rsp_t   push_data_i,
    input  logic       pop_i,
    output logic       head_ready_o,
    output obi_rsp_t   head_data_o,
    output logic [2:0] count_o
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  LOAD_CNT = 3'(LATENCY - 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]       count_q, count_d;
    obi_rsp_t         data_q [DEPTH];
    logic [2:0]       cd_q   [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign head_ready_o = (count_q != 3'd0) && (cd_q[rd_ptr_q] == 3'd0);
    assign head_data_o  = data_q[rd_ptr_q];
    assign count_o      = count_q;

    // Next-state pointers and occupancy; push and pop together leave count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset drops every queued response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a push into a slot overrides that slot's countdown.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                cd_q[i]   <= 3'd0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push_i && (wr_ptr_q == PTR_W'(i))) begin
                    data_q[i] <= push_data_i;
                    cd_q[i]   <= LOAD_CNT;
                end else if (cd_q[i] != 3'd0) begin
                    cd_q[i]   <= cd_q[i] - 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/obi_mem_responder.sv
// Memory-side OBI responder: word-addressed RAM, LFSR-driven grant stalls, in-order responses.
module obi_mem_responder
    import obi_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS_LOG2  = 8,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [15:0] LFSR_SEED       = LFSR_SEED_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      stall_en_i,
    obi_mem_responder_if.slave        bus,
    output logic [2:0]                outstanding_o
);

    localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;

    obi_req_t                  req_s;
    logic [MEM_WORDS_LOG2-1:0] word_idx_s;
    logic [31:0]               mem_q [MEM_WORDS];
    logic [15:0]               lfsr_q, lfsr_d;
    logic [2:0]                count_s;
    logic                      pop_s, full_s, stall_s, gnt_s;
    obi_rsp_t                  push_rsp_s, head_rsp_s;
    logic                      unused_addr_s;

    assign req_s         = '{addr: bus.addr, we: bus.we, be: bus.be, wdata: bus.wdata};
    assign word_idx_s    = req_s.addr[MEM_WORDS_LOG2+1:2];
    assign unused_addr_s = ^{req_s.addr[31:MEM_WORDS_LOG2+2], req_s.addr[1:0]};

    // Grant decision: a slot freed by this cycle's pop may be refilled in the same cycle.
    always_comb begin
        full_s           = (count_s == 3'(MAX_OUTSTANDING)) && !pop_s;
        stall_s          = stall_en_i && lfsr_q[0];
        gnt_s            = bus.req && !full_s && !stall_s;
        lfsr_d           = lfsr_next(lfsr_q);
        push_rsp_s.rdata = 32'd0;
        if (req_s.we) begin
            push_rsp_s.rdata = 32'd0;
        end else begin
            push_rsp_s.rdata = mem_q[word_idx_s];
        end
    end

    assign bus.gnt       = gnt_s;
    assign bus.rvalid    = pop_s;
    assign bus.rdata     = pop_s ? head_rsp_s.rdata : 32'd0;
    assign outstanding_o = count_s;

    // Stall LFSR free-runs every cycle independent of traffic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Backing RAM is deliberately not reset; granted writes merge under byte enables.
    always_ff @(posedge clk_i) begin
        if (gnt_s && req_s.we) begin
            mem_q[word_idx_s] <= apply_be(mem_q[word_idx_s], req_s.wdata, req_s.be);
        end
    end

    obi_rsp_queue #(
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_rsp_queue (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (gnt_s),
        .push_data_i  (push_rsp_s),
        .pop_i        (pop_s),
        .head_ready_o (pop_s),
        .head_data_o  (head_rsp_s),
        .count_o      (count_s)
    );

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three instances (latency 1, 3, 4) share one stimulus stream.
module tb_obi_mem_responder;
    import obi_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst_c = 1'b0, stall_en = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [3:0]  be = 4'd0;
    logic [2:0]  out_a, out_b, out_c;
    logic [15:0] lfsr_m;
    int          n_tests = 0, n_fail = 0, cyc = 0;
    int          a_gnt_cnt = 0, a_rv_cnt = 0;

    typedef struct { logic [31:0] rdata; int due; } sb_t;
    sb_t sb_q[$];

    typedef struct { logic w; logic [31:0] a; logic [3:0] b; logic [31:0] d; logic [31:0] exp; } avec_t;
    typedef struct { logic g; logic v; logic [31:0] rd; logic [2:0] o; } bvec_t;
    avec_t atab [8];
    bvec_t btab [11];

    always #5 clk = ~clk;

    obi_mem_responder_if ifa ();
    obi_mem_responder_if ifb ();
    obi_mem_responder_if ifc ();

    assign {ifa.req, ifa.we, ifa.addr, ifa.be, ifa.wdata} = {req, we, addr, be, wdata};
    assign {ifb.req, ifb.we, ifb.addr, ifb.be, ifb.wdata} = {req, we, addr, be, wdata};
    assign {ifc.req, ifc.we, ifc.addr, ifc.be, ifc.wdata} = {req, we, addr, be, wdata};

    obi_mem_responder #(.MEM_WORDS_LOG2(8), .LATENCY(1), .MAX_OUTSTANDING(2), .LFSR_SEED(16'hACE1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en), .bus(ifa), .outstanding_o(out_a));
    obi_mem_responder #(.MEM_WORDS_LOG2(8), .LATENCY(3), .MAX_OUTSTANDING(2), .LFSR_SEED(16'hACE1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en), .bus(ifb), .outstanding_o(out_b));
    obi_mem_responder #(.MEM_WORDS_LOG2(8), .LATENCY(4), .MAX_OUTSTANDING(2), .LFSR_SEED(16'hACE1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n & rst_c), .stall_en_i(stall_en), .bus(ifc), .outstanding_o(out_c));

    always @(posedge clk) cyc <= cyc + 1;

    // Reference stall LFSR: x^16+x^14+x^13+x^11, shifting right.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] pre(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {16'hC0DE, b, ~b};
    endfunction

    // One bus cycle: drive after the edge, then predict and check instance A's grant.
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd);
        logic exp_g;
        @(posedge clk);
        #1;
        req = r; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        exp_g = r && !(stall_en && lfsr_m[0]);
        chk("a_gnt", {31'd0, ifa.gnt}, {31'd0, exp_g});
        if (exp_g) begin
            sb_q.push_back('{rdata: exp_rd, due: cyc + 1});
            a_gnt_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
    endtask

    // Scoreboard for instance A: every rvalid pops the oldest expectation and must be on time.
    always @(negedge clk) begin : mon_a
        sb_t e;
        if (ifa.rvalid === 1'b1) begin
            a_rv_cnt++;
            if (sb_q.size() == 0) begin
                chk("a_rvalid_unexpected", {31'd0, ifa.rvalid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("a_rdata", ifa.rdata, e.rdata);
                chk("a_rvalid_cycle", 32'(cyc), 32'(e.due));
            end
        end else begin
            chk("a_rdata_idle", ifa.rdata, 32'd0);
            if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                chk("a_rvalid_missing", {31'd0, ifa.rvalid}, 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        atab[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000};
        atab[1] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF};
        atab[2] = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0000_0000};
        atab[3] = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0000_0000};
        atab[4] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0000_0000, 32'h11BB_33DD};
        atab[5] = '{1'b1, 32'h0000_0400, 4'hF, 32'h0000_1234, 32'h0000_0000};
        atab[6] = '{1'b0, 32'h0000_0003, 4'hF, 32'h0000_0000, 32'h0000_1234};
        atab[7] = '{1'b0, 32'h0000_0413, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF};

        btab[0]  = '{1'b1, 1'b0, 32'd0,   3'd0};
        btab[1]  = '{1'b1, 1'b0, 32'd0,   3'd1};
        btab[2]  = '{1'b0, 1'b0, 32'd0,   3'd2};
        btab[3]  = '{1'b1, 1'b1, pre(64), 3'd2};
        btab[4]  = '{1'b1, 1'b1, pre(65), 3'd2};
        btab[5]  = '{1'b0, 1'b0, 32'd0,   3'd2};
        btab[6]  = '{1'b1, 1'b1, pre(67), 3'd2};
        btab[7]  = '{1'b0, 1'b1, pre(68), 3'd2};
        btab[8]  = '{1'b0, 1'b0, 32'd0,   3'd1};
        btab[9]  = '{1'b0, 1'b1, pre(70), 3'd1};
        btab[10] = '{1'b0, 1'b0, 32'd0,   3'd0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst_c = 1'b1;
        @(negedge clk);
        chk("rst_a_ctl",   {27'd0, ifa.gnt, ifa.rvalid, out_a}, 32'd0);
        chk("rst_a_rdata", ifa.rdata, 32'd0);
        chk("rst_b_ctl",   {27'd0, ifb.gnt, ifb.rvalid, out_b}, 32'd0);
        chk("rst_b_rdata", ifb.rdata, 32'd0);
        chk("rst_c_ctl",   {27'd0, ifc.gnt, ifc.rvalid, out_c}, 32'd0);
        chk("rst_c_rdata", ifc.rdata, 32'd0);

        // Preload all words; gaps keep the slower instances from filling up.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 32'(i << 2), 4'hF, pre(i), 32'd0);
            idle(4);
        end
        idle(6);

        // Back-to-back write/read vectors on instance A (byte enables, aliasing).
        for (int i = 0; i < 8; i++) begin
            step(1'b1, atab[i].w, atab[i].a, atab[i].b, atab[i].d, atab[i].exp);
        end
        idle(10);

        // Back-pressure on instance B with req held high over distinct words.
        for (int k = 0; k < 11; k++) begin
            step(k < 7, 1'b0, 32'((64 + k) << 2), 4'hF, 32'd0, pre(64 + k));
            chk("b_gnt",         {31'd0, ifb.gnt},    {31'd0, btab[k].g});
            chk("b_rvalid",      {31'd0, ifb.rvalid}, {31'd0, btab[k].v});
            chk("b_rdata",       ifb.rdata,           btab[k].rd);
            chk("b_outstanding", {29'd0, out_b},      {29'd0, btab[k].o});
        end
        idle(6);

        // Random stalls: instance A's grants must follow the seeded LFSR.
        stall_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step(1'b1, 1'b0, 32'((64 + k % 64) << 2), 4'hF, 32'd0, pre(64 + k % 64));
        end
        idle(1);
        stall_en = 1'b0;
        idle(4);
        chk("a_drain_counts", 32'(a_rv_cnt), 32'(a_gnt_cnt));
        chk("a_drain_queue", 32'(sb_q.size()), 32'd0);
        idle(10);

        // Reset of instance C with two reads in flight.
        step(1'b1, 1'b0, 32'(64 << 2), 4'hF, 32'd0, pre(64));
        chk("c_gnt0", {31'd0, ifc.gnt}, 32'd1);
        step(1'b1, 1'b0, 32'(65 << 2), 4'hF, 32'd0, pre(65));
        chk("c_gnt1", {31'd0, ifc.gnt}, 32'd1);
        idle(1);
        chk("c_out_before_rst", {29'd0, out_c}, 32'd2);
        rst_c = 1'b0;
        @(posedge clk);
        #2;
        rst_c = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
            chk("c_rvalid_after_rst", {31'd0, ifc.rvalid}, 32'd0);
            chk("c_out_after_rst",    {29'd0, out_c},      32'd0);
        end
        step(1'b1, 1'b0, 32'(66 << 2), 4'hF, 32'd0, pre(66));
        chk("c_gnt_after_rst", {31'd0, ifc.gnt}, 32'd1);
        for (int j = 1; j <= 6; j++) begin
            step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
            chk("c_rvalid_latency", {31'd0, ifc.rvalid}, (j == 4) ? 32'd1 : 32'd0);
            chk("c_rdata", ifc.rdata, (j == 4) ? pre(66) : 32'd0);
        end
        idle(4);
        chk("a_final_counts", 32'(a_rv_cnt), 32'(a_gnt_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
